alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width, derived and not overridden.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port start, input, 1, operation request, sampled on clk rising edge.
REQ-006 Port ALUSrcA, input, WIDTH, operand A.
REQ-007 Port ALUSrcB, input, WIDTH, operand B.
REQ-008 Port ALUControl, input, 4, operation select.
REQ-009 Port ALUResult, output, WIDTH, registered result.
REQ-010 Port busy, output, 1, operation in progress.
REQ-011 Port done, output, 1, single-cycle completion pulse.
REQ-012 Port div_by_zero, output, 1, sticky flag for the last completed divide/remainder; valid while the result is held.

Function
REQ-013 ALUControl codes SHALL be: 0001 add; 0010 sub; 0011 OR; 0100 AND; 0101 equal (result 1/0); 0110 not-equal (result 1/0); 0111 mul (low WIDTH bits, unsigned); 1000 divu quotient; 1001 remu remainder; all other codes produce result 0.
REQ-014 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-015 start SHALL be accepted only when busy=0 (IDLE or DONE); start while busy=1 SHALL be ignored with no effect on state, operands or result.
REQ-016 On acceptance, ALUSrcA, ALUSrcB and ALUControl SHALL be latched internally; later input changes SHALL not affect the operation.
REQ-017 Single-cycle codes (0001-0110 and undefined codes): accepted at edge N -> ALUResult updated and done=1 after edge N+1; busy stays 0.
REQ-018 Iterative codes (0111-1001): accepted at edge N -> state EXEC, busy=1 from edge N+1; exactly WIDTH iterations, one per cycle; result written and done=1 after edge N+WIDTH+1; busy=0 in that same cycle.
REQ-019 mul SHALL use shift-and-add over operand B bits LSB first; the upper product bits are discarded.
REQ-020 divu/remu SHALL use restoring division, one quotient bit per cycle, MSB first.
REQ-021 Divisor 0: quotient SHALL be all ones, remainder SHALL equal ALUSrcA, and div_by_zero=1. The same WIDTH+1 latency SHALL apply.
REQ-022 div_by_zero SHALL be set or cleared on every completion and cleared to 0 for non-divide operations.
REQ-023 add/sub SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-024 done SHALL be high exactly one cycle per accepted operation (state DONE), then return to IDLE unless a new start is accepted in DONE, in which case the next operation begins.
REQ-025 ALUResult SHALL hold its value from completion until the next completion; it SHALL not change during EXEC.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, ALUResult=0, busy=0, done=0, div_by_zero=0, counter=0, independent of clk.
REQ-027 Reset asserted mid-EXEC SHALL abort the operation with no done pulse; start SHALL be accepted on the first clk edge after reset deasserts.

Verification
REQ-028 WIDTH=64, add 5+7 -> ALUResult=12, done one cycle after acceptance, busy never 1.
REQ-029 sub 0-1 -> ALUResult=0xFFFF_FFFF_FFFF_FFFF; equal 9,9 -> 1; not-equal 9,9 -> 0; code 1111 -> 0.
REQ-030 mul 0x1_0000_0000 * 0x1_0000_0003 -> ALUResult=0x0000_0003_0000_0000, done exactly 65 cycles after acceptance.
REQ-031 divu 100/7 -> 14; remu 100/7 -> 2; div_by_zero=0; remu 100/0 -> 100, div_by_zero=1; divu 100/0 -> all ones.
REQ-032 start pulsed with new operands at cycle 10 of a mul -> ignored; original product delivered; a single done pulse.
REQ-033 reset at cycle 20 of a divu -> all outputs 0 immediately, no done; next add 1+1 -> 2 with normal latency.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multicycle ALU: one-cycle arithmetic/logic ops plus iterative shift-add multiply
// and restoring divide, behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ALUSrcA,
  input  logic [WIDTH-1:0] ALUSrcB,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_EQ   = 4'b0101;
  localparam logic [3:0] OP_NE   = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_DIVU = 4'b1000;
  localparam logic [3:0] OP_REMU = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_single;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_accept;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  assign w_accept = start && (r_state != S_EXEC);
  // Restoring-divide step: bring in the next dividend bit, trial-subtract divisor.
  assign w_shift  = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_b};

  always_comb begin
    w_single = {WIDTH{1'b0}};
    case (r_op)
      OP_ADD:  w_single = r_a + r_b;
      OP_SUB:  w_single = r_a - r_b;
      OP_OR:   w_single = r_a | r_b;
      OP_AND:  w_single = r_a & r_b;
      OP_EQ:   w_single = {{(WIDTH-1){1'b0}}, (r_a == r_b)};
      OP_NE:   w_single = {{(WIDTH-1){1'b0}}, (r_a != r_b)};
      default: w_single = {WIDTH{1'b0}};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_op     <= 4'b0000;
      r_acc    <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= S_EXEC;
            r_a     <= ALUSrcA;
            r_b     <= ALUSrcB;
            r_op    <= ALUControl;
            r_acc   <= {WIDTH{1'b0}};
            r_quo   <= ALUSrcA;
            r_rem   <= {(WIDTH+1){1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= is_iter(ALUControl);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (!is_iter(r_op)) begin
            r_result <= w_single;
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end else if (r_cnt == CNT_W'(WIDTH)) begin
            // A zero divisor falls out naturally: quotient all ones, remainder = dividend.
            case (r_op)
              OP_MUL:  r_result <= r_acc;
              OP_DIVU: r_result <= r_quo;
              default: r_result <= r_rem[WIDTH-1:0];
            endcase
            r_dbz   <= (r_op != OP_MUL) && (r_b == {WIDTH{1'b0}});
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_op == OP_MUL) begin
              r_acc <= r_b[0] ? (r_acc + r_a) : r_acc;
              r_a   <= r_a << 1;
              r_b   <= r_b >> 1;
            end else begin
              r_rem <= w_diff[WIDTH] ? w_shift : w_diff;
              r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ALUResult   = r_result;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: driver pushes reference results,
// a negedge monitor pops and compares whenever done is presented.
module tb_alu_multicycle;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] ALUSrcA;
  logic [63:0] ALUSrcB;
  logic [3:0]  ALUControl;
  logic [63:0] ALUResult;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  alu_multicycle #(.WIDTH(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUControl  (ALUControl),
    .ALUResult   (ALUResult),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_iter(input logic [3:0] op);
    return (op == 4'd7) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // Reference behaviour straight from the operation table.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, output logic dbz);
    logic [63:0] r;
    dbz = ((op == 4'd8) || (op == 4'd9)) && (b == 64'd0);
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = a - b;
      4'd3:    r = a | b;
      4'd4:    r = a & b;
      4'd5:    r = (a == b) ? 64'd1 : 64'd0;
      4'd6:    r = (a != b) ? 64'd1 : 64'd0;
      4'd7:    r = a * b;
      4'd8:    r = (b == 64'd0) ? ~64'd0 : a / b;
      4'd9:    r = (b == 64'd0) ? a : a % b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", ALUResult, mon_e.res);
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  // Issue one operation at a negedge and follow it until done (or abort it with reset).
  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int inject_at, input int reset_at);
    exp_t        e;
    logic [63:0] r0;
    logic        bs;
    logic        chg;
    logic        seen;
    e.res = model(op, a, b, e.dbz);
    e.acc = cyc + 1;
    e.lat = is_iter(op) ? 65 : 1;
    exp_q.push_back(e);
    ALUControl = op;
    ALUSrcA    = a;
    ALUSrcB    = b;
    start      = 1'b1;
    r0   = ALUResult;
    bs   = 1'b0;
    chg  = 1'b0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    start      = 1'b0;
    ALUSrcA    = {$urandom, $urandom};
    ALUSrcB    = {$urandom, $urandom};
    ALUControl = 4'($urandom_range(0, 15));
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == reset_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_result", ALUResult, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        e = exp_q.pop_back();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        return;
      end
      if (i == inject_at) begin
        start      = 1'b1;
        ALUControl = 4'd1;
        ALUSrcA    = {$urandom, $urandom};
        ALUSrcB    = {$urandom, $urandom};
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      bs = bs | busy;
      if (ALUResult !== r0) chg = 1'b1;
    end
    chk("done_seen", {63'd0, seen}, 64'd1);
    if (!seen && exp_q.size() > 0) e = exp_q.pop_front();
    chk("busy_during_op", {63'd0, bs}, {63'd0, is_iter(op)});
    chk("result_hold", {63'd0, chg}, 64'd0);
    if (seen) chk("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    reset      = 1'b1;
    start      = 1'b0;
    ALUSrcA    = 64'd0;
    ALUSrcB    = 64'd0;
    ALUControl = 4'd0;
    repeat (2) @(negedge clk);
    chk("init_result", ALUResult, 64'd0);
    chk("init_busy", {63'd0, busy}, 64'd0);
    chk("init_done", {63'd0, done}, 64'd0);
    chk("init_dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(4'd1, 64'd5, 64'd7, -1, -1);
    run_op(4'd2, 64'd0, 64'd1, -1, -1);
    run_op(4'd5, 64'd9, 64'd9, -1, -1);
    run_op(4'd6, 64'd9, 64'd9, -1, -1);
    run_op(4'd15, 64'd3, 64'd4, -1, -1);
    run_op(4'd7, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0003, 10, -1);
    repeat (3) @(negedge clk);
    run_op(4'd8, 64'd100, 64'd7, -1, -1);
    run_op(4'd9, 64'd100, 64'd7, -1, -1);
    run_op(4'd9, 64'd100, 64'd0, -1, -1);
    run_op(4'd8, 64'd100, 64'd0, -1, -1);
    run_op(4'd3, 64'h00F0, 64'h0F00, -1, -1);
    run_op(4'd8, 64'hDEAD_BEEF_0000_1234, 64'd3, -1, 20);
    run_op(4'd1, 64'd1, 64'd1, -1, -1);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'd0;
        1:       b = 64'($urandom_range(1, 20));
        2:       b = a;
        default: b = {$urandom, $urandom};
      endcase
      run_op(op, a, b, -1, -1);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
